// File: rtl/gpio_cmd_master_pkg.sv
// -----------------------------------------------------------------------------
// gpio_cmd_master_pkg
// Shared definitions for the GPIO command bus initiator and its consumer:
//   - opcode constants of the 3-bit GPIO command bus (also used by the
//     convolution control block)
//   - default bus widths
//   - state encodings of the command FSM and of the strobe sequencer
//   - opcode legality helper
// -----------------------------------------------------------------------------
package gpio_cmd_master_pkg;

    // Default widths of the GPIO command bus
    localparam int DATA_W_DEF  = 24;
    localparam int CTRL_W_DEF  = 3;
    localparam int RDATA_W_DEF = 32;

    // Opcodes understood by the control block
    localparam logic [2:0] KERNEL_LOAD  = 3'd0;
    localparam logic [2:0] IMGSIZE_LOAD = 3'd1;
    localparam logic [2:0] IMG_LOAD     = 3'd2;
    localparam logic [2:0] DATA_REQUEST = 3'd3;
    localparam logic [2:0] GO_TO_RUN    = 3'd4;

    // Command FSM states (top level)
    typedef enum logic [2:0] {
        CS_IDLE     = 3'd0,   // waiting for a command, ready high
        CS_SEQ      = 3'd1,   // strobe sequencer running SETUP/STROBE/GAP
        CS_BAD_OP   = 3'd2,   // illegal opcode, no bus activity
        CS_WAIT_EOP = 3'd3,   // go-to-run issued, waiting for EOP rising edge
        CS_RSP      = 3'd4    // response presented, waiting for consumer
    } cmd_state_e;

    // Strobe sequencer states
    typedef enum logic [1:0] {
        SS_IDLE   = 2'd0,
        SS_SETUP  = 2'd1,
        SS_STROBE = 2'd2,
        SS_GAP    = 2'd3
    } strobe_state_e;

    // Opcodes above GO_TO_RUN have no meaning on the bus
    function automatic logic op_is_legal(input logic [31:0] op);
        return (op <= 32'(GO_TO_RUN));
    endfunction

endpackage

// File: rtl/gpio_cmd_master_strobe_gen.sv
// -----------------------------------------------------------------------------
// gpio_strobe_gen
// Times one GPIO transfer: SETUP_CYC cycles with valid low (ctrl/data already
// stable), STROBE_CYC cycles with valid high, then GAP_CYC cycles with valid
// low so the receiver's edge detector re-arms before the next strobe.
//
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   start   in   one-cycle request to begin a transfer (ignored while busy)
//   strobe  out  registered GPIO valid line
//   done    out  registered pulse, high during the last GAP cycle; the owner
//                samples read-back data and moves on at the end of that cycle
// -----------------------------------------------------------------------------
module gpio_strobe_gen
    import gpio_cmd_master_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int GAP_CYC    = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic strobe,
    output logic done
);

    localparam int MAX_A   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_CYC = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    strobe_state_e     state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              strobe_r;
    logic              done_r;

    // Saturating increment of the phase counter
    always_comb begin
        cnt_inc_s = cnt_r;
        if (cnt_r == {CNT_W{1'b1}}) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + CNT_W'(1);
        end
    end

    // Phase sequencing; valid and done are set one edge ahead so both are registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= SS_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            strobe_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                SS_IDLE: begin
                    strobe_r <= 1'b0;
                    cnt_r    <= {CNT_W{1'b0}};
                    if (start) begin
                        state_r <= SS_SETUP;
                    end
                end
                SS_SETUP: begin
                    if (cnt_r == CNT_W'(SETUP_CYC - 1)) begin
                        state_r  <= SS_STROBE;
                        cnt_r    <= {CNT_W{1'b0}};
                        strobe_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                SS_STROBE: begin
                    if (cnt_r == CNT_W'(STROBE_CYC - 1)) begin
                        state_r  <= SS_GAP;
                        cnt_r    <= {CNT_W{1'b0}};
                        strobe_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                SS_GAP: begin
                    if (cnt_r == CNT_W'(GAP_CYC - 1)) begin
                        state_r <= SS_IDLE;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_inc_s;
                        // GAP_CYC >= 2, so the last gap cycle is always entered from here
                        if (cnt_r == CNT_W'(GAP_CYC - 2)) begin
                            done_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r  <= SS_IDLE;
                    cnt_r    <= {CNT_W{1'b0}};
                    strobe_r <= 1'b0;
                end
            endcase
        end
    end

    assign strobe = strobe_r;
    assign done   = done_r;

endmodule

// File: rtl/gpio_cmd_master.sv
// -----------------------------------------------------------------------------
// gpio_cmd_master
// Host-side initiator of the 3-bit-opcode / 24-bit-data GPIO command bus.
// Takes commands from a valid/ready stream, drives ctrl/data, produces a clean
// rising edge on o_GPIOvalid, captures read-back for DATA_REQUEST, waits for
// the end-of-processing edge after GO_TO_RUN and returns one response per
// command on a valid/ready response stream.
//
// Optional build macro: CMD_TIMEOUT_EN -- bounds the EOP wait to TIMEOUT_CYC
// cycles and reports err=1 on expiry. Without it the wait is unbounded.
//
// Ports:
//   i_CLK, i_rst_n            clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready   command handshake (ready only in IDLE)
//   i_cmd_ctrl/i_cmd_data     opcode and payload
//   o_GPIOctrl/o_GPIOdata     registered opcode/payload to the control block
//   o_GPIOvalid               strobe to the control block
//   i_GPIOrdata               read-back data from the control block
//   i_EOP                     end-of-processing from the control block
//   o_rsp_valid/i_rsp_ready   response handshake
//   o_rsp_data                captured read-back for DATA_REQUEST, else 0
//   o_rsp_err                 illegal opcode or EOP timeout
// -----------------------------------------------------------------------------
module gpio_cmd_master
    import gpio_cmd_master_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int CTRL_W      = CTRL_W_DEF,
    parameter int RDATA_W     = RDATA_W_DEF,
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 2,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic               i_CLK,
    input  logic               i_rst_n,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [CTRL_W-1:0]  i_cmd_ctrl,
    input  logic [DATA_W-1:0]  i_cmd_data,
    output logic [CTRL_W-1:0]  o_GPIOctrl,
    output logic [DATA_W-1:0]  o_GPIOdata,
    output logic               o_GPIOvalid,
    input  logic [RDATA_W-1:0] i_GPIOrdata,
    input  logic               i_EOP,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [RDATA_W-1:0] o_rsp_data,
    output logic               o_rsp_err
);

    // Timing parameters outside these bounds break the receiver's edge detection
    if (SETUP_CYC < 1 || STROBE_CYC < 1 || GAP_CYC < 2 || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("gpio_cmd_master: illegal timing parameters");
    end

    cmd_state_e         state_r;
    logic               cmd_ready_r;
    logic [CTRL_W-1:0]  gpio_ctrl_r;
    logic [DATA_W-1:0]  gpio_data_r;
    logic               op_read_r;
    logic               op_run_r;
    logic               rsp_valid_r;
    logic [RDATA_W-1:0] rsp_data_r;
    logic               rsp_err_r;
    logic               eop_hist_r;

    logic               accept_s;
    logic               legal_s;
    logic               start_s;
    logic               eop_rise_s;
    logic               strobe_s;
    logic               seq_done_s;

`ifdef CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]    to_cnt_r;
`endif

    // Command handshake decode and sequencer launch
    always_comb begin
        accept_s   = 1'b0;
        legal_s    = 1'b0;
        start_s    = 1'b0;
        eop_rise_s = 1'b0;
        legal_s    = op_is_legal(32'(i_cmd_ctrl));
        if (state_r == CS_IDLE) begin
            accept_s = i_cmd_valid & cmd_ready_r;
        end else begin
            accept_s = 1'b0;
        end
        start_s    = accept_s & legal_s;
        eop_rise_s = i_EOP & ~eop_hist_r;
    end

    gpio_strobe_gen #(
        .SETUP_CYC  (SETUP_CYC),
        .STROBE_CYC (STROBE_CYC),
        .GAP_CYC    (GAP_CYC)
    ) u_strobe_gen (
        .clk    (i_CLK),
        .rst_n  (i_rst_n),
        .start  (start_s),
        .strobe (strobe_s),
        .done   (seq_done_s)
    );

    // Command FSM, bus registers, read-back capture and EOP handling
    always_ff @(posedge i_CLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= CS_IDLE;
            cmd_ready_r <= 1'b0;
            gpio_ctrl_r <= {CTRL_W{1'b0}};
            gpio_data_r <= {DATA_W{1'b0}};
            op_read_r   <= 1'b0;
            op_run_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {RDATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
            eop_hist_r  <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            to_cnt_r    <= {TO_W{1'b0}};
`endif
        end else begin
            // History follows the line every cycle, so a level that is already
            // high when WAIT_EOP is entered is never mistaken for a new edge.
            eop_hist_r <= i_EOP;
            case (state_r)
                CS_IDLE: begin
                    if (accept_s) begin
                        cmd_ready_r <= 1'b0;
                        if (legal_s) begin
                            gpio_ctrl_r <= i_cmd_ctrl;
                            gpio_data_r <= i_cmd_data;
                            op_read_r   <= (i_cmd_ctrl == CTRL_W'(DATA_REQUEST));
                            op_run_r    <= (i_cmd_ctrl == CTRL_W'(GO_TO_RUN));
                            state_r     <= CS_SEQ;
                        end else begin
                            // Illegal opcode: bus registers keep the previous command
                            state_r <= CS_BAD_OP;
                        end
                    end else begin
                        cmd_ready_r <= 1'b1;
                    end
                end
                CS_SEQ: begin
                    if (seq_done_s) begin
                        if (op_run_r) begin
                            state_r <= CS_WAIT_EOP;
`ifdef CMD_TIMEOUT_EN
                            to_cnt_r <= {TO_W{1'b0}};
`endif
                        end else begin
                            state_r     <= CS_RSP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b0;
                            // Last gap cycle: control block has had GAP_CYC cycles to drive read-back
                            rsp_data_r  <= op_read_r ? i_GPIOrdata : {RDATA_W{1'b0}};
                        end
                    end
                end
                CS_BAD_OP: begin
                    state_r     <= CS_RSP;
                    rsp_valid_r <= 1'b1;
                    rsp_err_r   <= 1'b1;
                    rsp_data_r  <= {RDATA_W{1'b0}};
                end
                CS_WAIT_EOP: begin
                    // An edge in the same cycle as the limit wins over the timeout
                    if (eop_rise_s) begin
                        state_r     <= CS_RSP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b0;
                        rsp_data_r  <= {RDATA_W{1'b0}};
                    end
`ifdef CMD_TIMEOUT_EN
                    else if (to_cnt_r == TO_W'(TIMEOUT_CYC - 1)) begin
                        state_r     <= CS_RSP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                        rsp_data_r  <= {RDATA_W{1'b0}};
                    end else if (to_cnt_r != {TO_W{1'b1}}) begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
`endif
                end
                CS_RSP: begin
                    if (i_rsp_ready) begin
                        state_r     <= CS_IDLE;
                        cmd_ready_r <= 1'b1;
                        rsp_valid_r <= 1'b0;
                        rsp_err_r   <= 1'b0;
                        rsp_data_r  <= {RDATA_W{1'b0}};
                    end
                end
                default: begin
                    state_r     <= CS_IDLE;
                    cmd_ready_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    rsp_data_r  <= {RDATA_W{1'b0}};
                end
            endcase
        end
    end

    assign o_cmd_ready = cmd_ready_r;
    assign o_GPIOctrl  = gpio_ctrl_r;
    assign o_GPIOdata  = gpio_data_r;
    assign o_GPIOvalid = strobe_s;
    assign o_rsp_valid = rsp_valid_r;
    assign o_rsp_data  = rsp_data_r;
    assign o_rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_gpio_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_gpio_cmd_master
// Self-checking bench for gpio_cmd_master: a table of directed commands,
// hand-written reset / go-to-run / back-to-back sequences, and random commands
// compared with a small behavioural model of the command bus protocol.
// -----------------------------------------------------------------------------
module tb_gpio_cmd_master;

    localparam int SETUP_CYC  = 1;
    localparam int STROBE_CYC = 2;
    localparam int GAP_CYC    = 2;

    logic        i_CLK = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [2:0]  i_cmd_ctrl = 3'd0;
    logic [23:0] i_cmd_data = 24'd0;
    logic [2:0]  o_GPIOctrl;
    logic [23:0] o_GPIOdata;
    logic        o_GPIOvalid;
    logic [31:0] i_GPIOrdata = 32'd0;
    logic        i_EOP = 1'b0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic [31:0] o_rsp_data;
    logic        o_rsp_err;

    int total = 0;
    int bad   = 0;

    // behavioural model: last legal command seen on the bus
    logic [2:0]  mdl_ctrl = 3'd0;
    logic [23:0] mdl_data = 24'd0;
    bit          rsp_ready_always = 1'b0;

    // strobe monitor
    bit          mon_clear = 1'b0;
    logic [2:0]  ctrl_q[$];
    int          low_run = 0;
    int          min_low = 1000;
    bit          seen = 1'b0;
    bit          prev_v = 1'b0;

    gpio_cmd_master #(
        .DATA_W(24), .CTRL_W(3), .RDATA_W(32),
        .SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC), .GAP_CYC(GAP_CYC),
        .TIMEOUT_CYC(1048576)
    ) dut (
        .i_CLK(i_CLK), .i_rst_n(i_rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_ctrl(i_cmd_ctrl), .i_cmd_data(i_cmd_data),
        .o_GPIOctrl(o_GPIOctrl), .o_GPIOdata(o_GPIOdata), .o_GPIOvalid(o_GPIOvalid),
        .i_GPIOrdata(i_GPIOrdata), .i_EOP(i_EOP),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err)
    );

    always #5 i_CLK = ~i_CLK;

    // record strobe rising edges and valid-low run lengths between strobes
    always @(negedge i_CLK) begin
        if (mon_clear || !i_rst_n) begin
            low_run = 0;
            seen    = 1'b0;
            min_low = 1000;
            ctrl_q.delete();
        end else if (o_GPIOvalid) begin
            if (!prev_v) begin
                ctrl_q.push_back(o_GPIOctrl);
                if (seen && low_run < min_low) min_low = low_run;
                seen = 1'b1;
            end
            low_run = 0;
        end else begin
            low_run = low_run + 1;
        end
        prev_v = o_GPIOvalid;
    end

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command and check bus timing and the response.
    // Cycle n = the clock period after the (n-1)-th edge following the accept edge.
    task automatic do_cmd(input logic [2:0] ctrl, input logic [23:0] data, input logic [31:0] rdata,
                          input int hold, input bit eop_pre, input int eop_drop, input int eop_at,
                          input logic exp_err, input logic [31:0] exp_rdata);
        bit legal;
        int s_first, s_last, g_first, g_last, exp_rsp, n, cyc, bad_bus;
        bit got;
        legal   = (ctrl <= 3'd4);
        s_first = 1 + SETUP_CYC;
        s_last  = SETUP_CYC + STROBE_CYC;
        g_first = s_last + 1;
        g_last  = s_last + GAP_CYC;
        if (!legal)             exp_rsp = 2;
        else if (ctrl == 3'd4)  exp_rsp = eop_at + 1;
        else                    exp_rsp = g_last + 1;
        if (legal) begin
            mdl_ctrl = ctrl;
            mdl_data = data;
        end
        i_EOP = eop_pre;
        n = 0;
        while (!o_cmd_ready && n < 100) begin
            tick();
            n++;
        end
        check("ready_before_cmd", 64'(o_cmd_ready), 64'd1);
        i_cmd_valid = 1'b1;
        i_cmd_ctrl  = ctrl;
        i_cmd_data  = data;
        i_rsp_ready = rsp_ready_always;
        tick();
        // while busy, offered commands must be ignored
        i_cmd_ctrl = 3'($urandom);
        i_cmd_data = 24'($urandom);
        cyc = 1;
        bad_bus = 0;
        got = 1'b0;
        check("gpio_ctrl", 64'(o_GPIOctrl), 64'(mdl_ctrl));
        check("gpio_data", 64'(o_GPIOdata), 64'(mdl_data));
        while (!got && cyc < exp_rsp + 20 && cyc < 400) begin
            if (o_rsp_valid) begin
                got = 1'b1;
            end else begin
                if (o_GPIOvalid !== (legal && cyc >= s_first && cyc <= s_last)) bad_bus++;
                if (o_cmd_ready !== 1'b0) bad_bus++;
                i_GPIOrdata = (cyc >= g_first && cyc <= g_last) ? rdata : ~rdata;
                if (eop_pre && cyc == eop_drop) i_EOP = 1'b0;
                if (ctrl == 3'd4 && cyc == eop_at) i_EOP = 1'b1;
                tick();
                cyc++;
            end
        end
        i_cmd_valid = 1'b0;
        check("rsp_seen", 64'(got), 64'd1);
        check("rsp_cycle", 64'(cyc), 64'(exp_rsp));
        check("busy_bus_timing", 64'(bad_bus), 64'd0);
        check("rsp_err", 64'(o_rsp_err), 64'(exp_err));
        check("rsp_data", 64'(o_rsp_data), 64'(exp_rdata));
        if (got) begin
            for (int h = 0; h < hold; h++) begin
                tick();
                check("rsp_hold", {31'd0, o_rsp_valid, o_rsp_err, o_rsp_data},
                      {31'd0, 1'b1, exp_err, exp_rdata});
            end
            i_rsp_ready = 1'b1;
            tick();
            i_rsp_ready = 1'b0;
            check("rsp_release", 64'({o_rsp_valid, o_cmd_ready}), 64'(2'b01));
        end
        i_EOP = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  ctrl;
        logic [23:0] data;
        logic [31:0] rdata;
        int          hold;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int g_last;
        logic [2:0]  rc;
        logic [23:0] rd;
        logic [31:0] rr;
        int          rh, eat;
        g_last = SETUP_CYC + STROBE_CYC + GAP_CYC;

        vecs[0] = '{3'd0, 24'h0A0B0C, 32'hDEADBEEF, 0, 1'b0, 32'h0};
        vecs[1] = '{3'd1, 24'h000200, 32'h12345678, 1, 1'b0, 32'h0};
        vecs[2] = '{3'd2, 24'hFFFFFF, 32'h55AA55AA, 0, 1'b0, 32'h0};
        vecs[3] = '{3'd3, 24'h000000, 32'h000000AB, 3, 1'b0, 32'h000000AB};
        vecs[4] = '{3'd6, 24'h123456, 32'hCAFEF00D, 0, 1'b1, 32'h0};
        vecs[5] = '{3'd5, 24'h654321, 32'h00000001, 2, 1'b1, 32'h0};
        vecs[6] = '{3'd3, 24'h00ABCD, 32'hFFFFFFFF, 2, 1'b0, 32'hFFFFFFFF};

        // power-on reset: all outputs low
        #3;
        check("reset_outputs", {1'b0, o_cmd_ready, o_GPIOctrl, o_GPIOdata, o_GPIOvalid,
                                o_rsp_valid, o_rsp_data, o_rsp_err}, 64'd0);
        #20 i_rst_n = 1'b1;
        tick();
        check("ready_after_reset", 64'(o_cmd_ready), 64'd1);

        // directed table
        for (int i = 0; i < 7; i++) begin
            do_cmd(vecs[i].ctrl, vecs[i].data, vecs[i].rdata, vecs[i].hold,
                   1'b0, 0, 0, vecs[i].exp_err, vecs[i].exp_rdata);
        end

        // go-to-run: EOP high before accept, low in STROBE, high 50 cycles later
        do_cmd(3'd4, 24'h000001, 32'h0, 1, 1'b1, 1 + SETUP_CYC, 52, 1'b0, 32'h0);
        // go-to-run: EOP level still high when the wait starts must not complete
        do_cmd(3'd4, 24'h000002, 32'h0, 0, 1'b1, g_last + 6, g_last + 14, 1'b0, 32'h0);

        // back-to-back with response ready held high
        rsp_ready_always = 1'b1;
        mon_clear = 1'b1;
        tick();
        mon_clear = 1'b0;
        do_cmd(3'd1, 24'd512, 32'h0, 0, 1'b0, 0, 0, 1'b0, 32'h0);
        do_cmd(3'd2, 24'h00BEEF, 32'h0, 0, 1'b0, 0, 0, 1'b0, 32'h0);
        rsp_ready_always = 1'b0;
        tick();
        check("b2b_strobe_count", 64'(ctrl_q.size()), 64'd2);
        if (ctrl_q.size() == 2) begin
            check("b2b_ctrl_seq", 64'({ctrl_q[0], ctrl_q[1]}), 64'({3'd1, 3'd2}));
        end
        check("b2b_min_low", 64'(min_low >= GAP_CYC + SETUP_CYC + 1), 64'd1);

        // random commands against the model
        for (int k = 0; k < 30; k++) begin
            rc  = 3'($urandom_range(0, 7));
            rd  = 24'($urandom);
            rr  = $urandom;
            rh  = $urandom_range(0, 3);
            eat = g_last + 1 + $urandom_range(0, 10);
            do_cmd(rc, rd, rr, rh, 1'b0, 0, eat, (rc > 3'd4), (rc == 3'd3) ? rr : 32'h0);
        end

        // reset asserted mid-strobe
        while (!o_cmd_ready) tick();
        i_cmd_valid = 1'b1;
        i_cmd_ctrl  = 3'd0;
        i_cmd_data  = 24'h123456;
        tick();
        i_cmd_valid = 1'b0;
        tick();
        check("valid_before_reset", 64'(o_GPIOvalid), 64'd1);
        #2 i_rst_n = 1'b0;
        #1;
        check("reset_async_outputs", {1'b0, o_cmd_ready, o_GPIOctrl, o_GPIOdata, o_GPIOvalid,
                                      o_rsp_valid, o_rsp_data, o_rsp_err}, 64'd0);
        tick();
        tick();
        #3 i_rst_n = 1'b1;
        mdl_ctrl = 3'd0;
        mdl_data = 24'd0;
        begin
            int leaks;
            leaks = 0;
            for (int c = 0; c < 12; c++) begin
                tick();
                if (o_rsp_valid || o_GPIOvalid) leaks++;
            end
            check("no_rsp_after_reset", 64'(leaks), 64'd0);
        end
        // block still usable after the abort
        do_cmd(3'd3, 24'h000010, 32'h0000_5A5A, 0, 1'b0, 0, 0, 1'b0, 32'h0000_5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
